// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture and dump paths.
package la_pkg;
    localparam int ENTRIES_DEF = 384;
    localparam int LOG2_DEF    = 9;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        WAIT_TX,
        DONE
    } dump_state_t;
endpackage

// File: rtl/wrap_addr_cnt.sv
// Loadable address counter that wraps from ENTRIES-1 back to 0.
module wrap_addr_cnt
    import la_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int LOG2    = LOG2_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [LOG2-1:0] load_val_i,
    input  logic            inc_i,
    output logic [LOG2-1:0] cnt_o
);
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    logic [LOG2-1:0] cnt_q;
    logic [LOG2-1:0] cnt_d;

    // Load takes priority so a fresh start address is never lost to an increment.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/dump_reader.sv
// Replays the circular sample RAM oldest-first into the UART transmitter,
// then releases capture_done so a new capture can be armed.
module dump_reader
    import la_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int LOG2    = LOG2_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump,
    input  logic            capture_done,
    input  logic [LOG2-1:0] start_addr,
    input  logic [7:0]      rdata,
    input  logic            tx_done,
    output logic            ren,
    output logic [LOG2-1:0] raddr,
    output logic [7:0]      tx_data,
    output logic            trmt,
    output logic            dumping,
    output logic            dump_done,
    output logic            clr_capture_done
);
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    dump_state_t     state_q, state_d;
    logic [LOG2-1:0] count_q, count_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            trmt_q, trmt_d;
    logic            dumping_q, dumping_d;
    logic            addr_load;
    logic            addr_inc;

    wrap_addr_cnt #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (addr_load),
        .load_val_i (start_addr),
        .inc_i      (addr_inc),
        .cnt_o      (raddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            dumping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            dumping_q <= dumping_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        trmt_d    = 1'b0;
        dumping_d = dumping_q;
        addr_load = 1'b0;
        addr_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump && capture_done) begin
                    state_d   = READ;
                    count_d   = '0;
                    dumping_d = 1'b1;
                    addr_load = 1'b1;
                end
            end
            READ: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d   = WAIT_TX;
                tx_data_d = rdata;
                trmt_d    = 1'b1;
            end
            WAIT_TX: begin
                // A done seen alongside trmt belongs to the previous byte.
                if (tx_done && !trmt_q) begin
                    if (count_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d  = READ;
                        count_d  = count_q + 1'b1;
                        addr_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                dumping_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ren              = (state_q == READ);
    assign dump_done        = (state_q == DONE);
    assign clr_capture_done = (state_q == DONE);
    assign tx_data          = tx_data_q;
    assign trmt             = trmt_q;
    assign dumping          = dumping_q;
endmodule
